// File: rtl/jesd_multilane_descrambler.sv
// jesd_multilane_descrambler: per-lane JESD204B self-synchronising descrambler (1 + x^14 + x^15) with valid/ready output register
module jesd_multilane_descrambler #(
  parameter int          NUM_LANES     = 4,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [14:0] SEED          = 15'h7fff,
  parameter bit          LITTLE_ENDIAN = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic [NUM_LANES-1:0]            descramble_en_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_o,
  output logic [NUM_LANES-1:0]            sync_o
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [1:0] N = DATA_WIDTH == 8 ? 2'd2 : 2'd1;

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 8, 16, 32 or 64");
  end

  function automatic logic [DATA_WIDTH-1:0] swap(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    r = v;
    for (int k = 0; k < NB; k++) r[8*k +: 8] = LITTLE_ENDIAN ? v[8*(NB-1-k) +: 8] : v[8*k +: 8];
    return r;
  endfunction

  logic                            acc;
  logic [14:0]                     h  [NUM_LANES];
  logic [1:0]                      cnt[NUM_LANES];
  logic [DATA_WIDTH-1:0]           w  [NUM_LANES];
  logic [DATA_WIDTH+14:0]          x  [NUM_LANES];
  logic [14:0]                     nh [NUM_LANES];
  logic [1:0]                      nc [NUM_LANES];
  logic [NUM_LANES*DATA_WIDTH-1:0] dn;

  assign ready_o = !valid_o || ready_i;
  assign acc     = valid_i && ready_o;

  // clear_i seeds the history used by a coincident beat, so that beat sees SEED
  always_comb begin
    dn = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w[l] = swap(data_i[l*DATA_WIDTH +: DATA_WIDTH]);
      x[l] = {clear_i ? SEED : h[l], w[l]};
      dn[l*DATA_WIDTH +: DATA_WIDTH] = swap(descramble_en_i[l] ?
        x[l][DATA_WIDTH+14:15] ^ x[l][DATA_WIDTH+13:14] ^ w[l] : w[l]);
      nh[l] = acc ? x[l][14:0] : clear_i ? SEED : h[l];
      nc[l] = clear_i ? {1'b0, acc} : (acc && cnt[l] != N) ? cnt[l] + 2'd1 : cnt[l];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      sync_o  <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        h[l]   <= SEED;
        cnt[l] <= '0;
      end
    end else begin
      if (acc) begin
        valid_o <= 1'b1;
        data_o  <= dn;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
      for (int l = 0; l < NUM_LANES; l++) begin
        h[l]      <= nh[l];
        cnt[l]    <= nc[l];
        sync_o[l] <= nc[l] == N;
      end
    end
  end
endmodule

// File: tb/tb_jesd_multilane_descrambler.sv
// tb_jesd_multilane_descrambler: three DUT variants (32b big/little endian, 8b) against a bit-serial reference model
module tb_jesd_multilane_descrambler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] clr = '0, vin = '0, rin = '1;
  logic [2:0] rdy, vout;
  logic [3:0] en [3];
  logic [3:0] syn [3];
  logic [127:0] din0 = '0, din1 = '0, dout0, dout1;
  logic [31:0]  din2 = '0, dout2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  jesd_multilane_descrambler #(.NUM_LANES(4), .DATA_WIDTH(32), .SEED(15'h7fff), .LITTLE_ENDIAN(1'b0)) u_be32 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr[0]), .descramble_en_i(en[0]), .valid_i(vin[0]), .ready_o(rdy[0]),
    .data_i(din0), .valid_o(vout[0]), .ready_i(rin[0]), .data_o(dout0), .sync_o(syn[0]));
  jesd_multilane_descrambler #(.NUM_LANES(4), .DATA_WIDTH(32), .SEED(15'h7fff), .LITTLE_ENDIAN(1'b1)) u_le32 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr[1]), .descramble_en_i(en[1]), .valid_i(vin[1]), .ready_o(rdy[1]),
    .data_i(din1), .valid_o(vout[1]), .ready_i(rin[1]), .data_o(dout1), .sync_o(syn[1]));
  jesd_multilane_descrambler #(.NUM_LANES(4), .DATA_WIDTH(8), .SEED(15'h7fff), .LITTLE_ENDIAN(1'b1)) u_le8 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr[2]), .descramble_en_i(en[2]), .valid_i(vin[2]), .ready_o(rdy[2]),
    .data_i(din2), .valid_o(vout[2]), .ready_i(rin[2]), .data_o(dout2), .sync_o(syn[2]));

  function automatic int wd(int u);
    return u == 2 ? 8 : 32;
  endfunction

  function automatic int need(int u);
    return u == 2 ? 2 : 1;
  endfunction

  function automatic logic [63:0] reord(int u, logic [63:0] v);
    logic [63:0] r;
    int nb;
    r = v;
    nb = wd(u) / 8;
    if (u != 0) begin
      r = '0;
      for (int k = 0; k < nb; k++) r[8*k +: 8] = v[8*(nb-1-k) +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] din_lane(int u, int l);
    return u == 0 ? 64'(din0[32*l +: 32]) : u == 1 ? 64'(din1[32*l +: 32]) : 64'(din2[8*l +: 8]);
  endfunction

  function automatic logic [63:0] dout_lane(int u, int l);
    return u == 0 ? 64'(dout0[32*l +: 32]) : u == 1 ? 64'(dout1[32*l +: 32]) : 64'(dout2[8*l +: 8]);
  endfunction

  function automatic logic [127:0] dout_all(int u);
    return u == 0 ? dout0 : u == 1 ? dout1 : {96'b0, dout2};
  endfunction

  task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  // Reference: serial bit history per lane, oldest bit at index 0, MSB of the ordered word is earliest
  bit hb [3][4][15];
  int cnt [3][4];
  logic ev [3];
  logic [127:0] ed [3];
  logic [3:0] es [3];

  task automatic m_seed(int u, int l);
    logic [14:0] s;
    s = 15'h7fff;
    for (int k = 0; k < 15; k++) hb[u][l][k] = s[14-k];
    cnt[u][l] = 0;
  endtask

  task automatic m_beat(int u, int l);
    logic [63:0] w, o;
    bit s, p;
    w = reord(u, din_lane(u, l));
    o = '0;
    for (int j = wd(u) - 1; j >= 0; j--) begin
      s = w[j];
      p = s ^ hb[u][l][1] ^ hb[u][l][0];
      for (int k = 0; k < 14; k++) hb[u][l][k] = hb[u][l][k+1];
      hb[u][l][14] = s;
      o[j] = en[u][l] ? p : s;
    end
    o = reord(u, o);
    if (u == 2) ed[u][8*l +: 8] = o[7:0];
    else ed[u][32*l +: 32] = o[31:0];
    if (cnt[u][l] < need(u)) cnt[u][l]++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 3; u++) begin
        for (int l = 0; l < 4; l++) m_seed(u, l);
        ev[u] = 1'b0;
        ed[u] = '0;
        es[u] = '0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        bit acc;
        acc = vin[u] && (!ev[u] || rin[u]);
        if (clr[u]) for (int l = 0; l < 4; l++) m_seed(u, l);
        if (acc) begin
          for (int l = 0; l < 4; l++) m_beat(u, l);
          ev[u] = 1'b1;
        end else if (rin[u]) begin
          ev[u] = 1'b0;
        end
        for (int l = 0; l < 4; l++) es[u][l] = cnt[u][l] == need(u);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d_ready", u), 128'(rdy[u]), 128'(!ev[u] || rin[u]));
      chk($sformatf("u%0d_valid", u), 128'(vout[u]), 128'(ev[u]));
      if (ev[u]) chk($sformatf("u%0d_data", u), dout_all(u), ed[u]);
      chk($sformatf("u%0d_sync", u), 128'(syn[u]), 128'(es[u]));
    end
  end

  // Transmit-side scrambler used to build stimulus streams
  bit sh [4][15];

  task automatic sc_load(int l, logic [14:0] h);
    for (int k = 0; k < 15; k++) sh[l][k] = h[14-k];
  endtask

  task automatic sc_raw(int u, int l, logic [63:0] ww);
    logic [63:0] r;
    r = reord(u, ww);
    for (int j = wd(u) - 1; j >= 0; j--) begin
      for (int k = 0; k < 14; k++) sh[l][k] = sh[l][k+1];
      sh[l][14] = r[j];
    end
  endtask

  task automatic sc_enc(int u, int l, logic [63:0] p, output logic [63:0] c);
    logic [63:0] r, o;
    bit s;
    r = reord(u, p);
    o = '0;
    for (int j = wd(u) - 1; j >= 0; j--) begin
      s = r[j] ^ sh[l][1] ^ sh[l][0];
      for (int k = 0; k < 14; k++) sh[l][k] = sh[l][k+1];
      sh[l][14] = s;
      o[j] = s;
    end
    c = reord(u, o);
  endtask

  task automatic put(int u, int l, logic [63:0] w);
    if (u == 0) din0[32*l +: 32] = w[31:0];
    else if (u == 1) din1[32*l +: 32] = w[31:0];
    else din2[8*l +: 8] = w[7:0];
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [63:0] p, c;
    logic [31:0] pl [8], cw [8];
    int bi, oi;
    logic accp;
    for (int u = 0; u < 3; u++) en[u] = 4'hf;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_valid", 128'(vout), 128'(0));
    chk("reset_data", dout0, 128'(0));
    chk("reset_sync", 128'(syn[0]), 128'(0));

    vin[0] = 1'b1;
    tick();
    chk("A_beat1", dout_lane(0, 0), 128'h00020000);
    chk("A_model1", ed[0][31:0], 128'h00020000);
    chk("A_sync1", 128'(syn[0][0]), 128'(1));
    tick();
    chk("A_beat2", dout_lane(0, 0), 128'h0);
    vin[0] = 1'b0;

    vin[1] = 1'b1;
    tick();
    chk("B_beat1", dout_lane(1, 0), 128'h00000200);
    chk("B_model1", ed[1][31:0], 128'h00000200);
    tick();
    chk("B_beat2", dout_lane(1, 0), 128'h0);
    vin[1] = 1'b0;

    en[0] = 4'b1101;
    put(0, 1, 32'ha5a51234);
    vin[0] = 1'b1;
    tick();
    chk("C_bypass", dout_lane(0, 1), 128'ha5a51234);
    sc_raw(0, 1, 32'ha5a51234);
    en[0] = 4'hf;
    for (int i = 0; i < 4; i++) begin
      p = 64'($urandom);
      sc_enc(0, 1, p, c);
      put(0, 1, c);
      tick();
      chk("C_plain", dout_lane(0, 1), 128'(p));
    end
    vin[0] = 1'b0;
    tick();

    sc_load(2, 15'h0);
    for (int k = 0; k < 8; k++) begin
      pl[k] = $urandom;
      sc_enc(0, 2, 64'(pl[k]), c);
      cw[k] = c[31:0];
    end
    bi = 0;
    oi = 0;
    accp = 1'b0;
    for (int cy = 0; cy < 30 && oi < 8; cy++) begin
      if (accp) begin
        chk("D_plain", dout_lane(0, 2), 128'(pl[oi]));
        oi++;
      end
      rin[0] = !(cy >= 3 && cy <= 5);
      vin[0] = bi < 8;
      if (bi < 8) put(0, 2, 64'(cw[bi]));
      #1;
      if (!rin[0] && vout[0]) chk("D_stall_ready", 128'(rdy[0]), 128'(0));
      accp = vin[0] && rdy[0];
      if (accp) bi++;
      tick();
    end
    chk("D_beats_out", 128'(oi), 128'(8));
    vin[0] = 1'b0;
    rin[0] = 1'b1;
    tick();

    sc_load(0, 15'h1234);
    vin[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      p = 64'($urandom_range(255));
      sc_enc(2, 0, p, c);
      put(2, 0, c);
      tick();
      if (k == 1) chk("E_sync_b1", 128'(syn[2][0]), 128'(0));
      if (k == 2) chk("E_sync_b2", 128'(syn[2][0]), 128'(1));
      if (k >= 3) chk("E_plain", dout_lane(2, 0), 128'(p));
    end
    vin[2] = 1'b0;
    tick();

    put(0, 0, 32'h12345678);
    vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    rin[0] = 1'b0;
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("F_clear_sync", 128'(syn[0]), 128'(0));
    chk("F_hold_valid", 128'(vout[0]), 128'(1));
    rin[0] = 1'b1;
    vin[0] = 1'b1;
    clr[0] = 1'b1;
    din0 = '0;
    tick();
    clr[0] = 1'b0;
    chk("F_clear_beat", dout_lane(0, 0), 128'h00020000);
    chk("F_clear_sync1", 128'(syn[0]), 128'hf);

    put(0, 0, 32'hdeadbeef);
    tick();
    rin[0] = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    chk("G_rst_valid", 128'(vout[0]), 128'(0));
    chk("G_rst_sync", 128'(syn[0]), 128'(0));
    chk("G_rst_data", dout0, 128'(0));
    tick();
    rst = 1'b0;
    rin[0] = 1'b1;
    din0 = '0;
    tick();
    chk("G_after_rst", dout_lane(0, 0), 128'h00020000);
    vin[0] = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
